// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: fills OUT_W-bit stimulus vectors one 32-bit LCG word per cycle and commits each whole vector at once
//   clk, rst_n (async, active-low)
//   start/seed/cycles: launch a run of cycles+1 vectors from seed; stall freezes generation
//   in_flat/vec_valid: committed vector and its one-cycle strobe
//   busy/done/vec_count/rng_state: run status, commit count, current LCG state
module lcg_stim_gen #(
  parameter int OUT_W = 138,
  parameter int NW = (OUT_W + 31) / 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [31:0]      cycles,
  input  logic             stall,
  output logic [OUT_W-1:0] in_flat,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      vec_count,
  output logic [31:0]      rng_state
);
  localparam int KW = NW > 1 ? $clog2(NW) : 1;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [32*NW-1:0] shadow, shadow_n;
  logic [32:0] remaining;
  logic [31:0] nxt;
  logic accept, step_en, last, fin;
  assign nxt = rng_state * 32'h41C64E6D + 32'h3039;
  assign accept = start && state != FILL;
  assign step_en = state == FILL && !stall;
  assign last = step_en && k == KW'(NW - 1);
  // the 33-bit count lets cycles=FFFFFFFF still mean 2^32 vectors
  assign fin = last && remaining == 33'd1;
  assign busy = state == FILL;
  assign done = state == DONE;
  // shadow with the word being generated this cycle merged in; the commit takes it whole
  always_comb begin
    shadow_n = shadow;
    shadow_n[32*k +: 32] = nxt;
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = FILL;
    else if (fin) state_n = DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      shadow <= '0;
      in_flat <= '0;
      vec_valid <= 1'b0;
      vec_count <= '0;
      rng_state <= '0;
      remaining <= '0;
    end else begin
      vec_valid <= last;
      if (accept) begin
        rng_state <= seed;
        k <= '0;
        vec_count <= '0;
        remaining <= {1'b0, cycles} + 33'd1;
      end else if (step_en) begin
        rng_state <= nxt;
        shadow <= shadow_n;
        k <= last ? '0 : k + KW'(1);
        if (last) begin
          in_flat <= OUT_W'(shadow_n);
          vec_count <= vec_count + 32'd1;
          remaining <= remaining - 33'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: directed and randomized checks of lcg_stim_gen against an arithmetic LCG sequence model
module tb_lcg_stim_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stall = 1'b0;
  logic [31:0] seed = '0, cycles = '0;
  logic [137:0] in_flat;
  logic vec_valid, busy, done;
  logic [31:0] vec_count, rng_state;
  logic start2 = 1'b0, stall2 = 1'b0;
  logic [31:0] seed2 = '0, cycles2 = '0;
  logic [31:0] in_flat2;
  logic vec_valid2, busy2, done2;
  logic [31:0] vec_count2, rng_state2;
  int errors = 0, checks = 0;

  lcg_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .cycles(cycles), .stall(stall),
    .in_flat(in_flat), .vec_valid(vec_valid), .busy(busy), .done(done),
    .vec_count(vec_count), .rng_state(rng_state)
  );

  lcg_stim_gen #(.OUT_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .cycles(cycles2), .stall(stall2),
    .in_flat(in_flat2), .vec_valid(vec_valid2), .busy(busy2), .done(done2),
    .vec_count(vec_count2), .rng_state(rng_state2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return 32'((64'(x) * 64'd1103515245 + 64'd12345) % 64'h1_0000_0000);
  endfunction

  function automatic logic [31:0] lcgn(input logic [31:0] x, input int n);
    logic [31:0] s;
    s = x;
    for (int i = 0; i < n; i++) s = lcg(s);
    return s;
  endfunction

  // vector j of a run from s: the nw words following the first j*nw draws
  function automatic logic [159:0] vec(input logic [31:0] s, input int j, input int nw);
    logic [31:0] st;
    logic [159:0] v;
    st = lcgn(s, j * nw);
    v = '0;
    for (int i = 0; i < nw; i++) begin
      st = lcg(st);
      v[32*i +: 32] = st;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] c);
    seed = s;
    cycles = c;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic collect(input logic [31:0] s, input logic [31:0] c, input bit rnd, input int g0, input string tag);
    int j, gap, bud, stab, extra;
    logic [137:0] prev;
    logic [159:0] e;
    bit stl;
    j = 0; gap = g0; bud = 0; stab = 0; stl = 0; extra = 0;
    prev = in_flat;
    while (!done && bud < 3000) begin
      stall = rnd && ($urandom_range(0, 3) == 0);
      stl = stl | stall;
      tick;
      bud++;
      gap++;
      if (vec_valid) begin
        e = vec(s, j, 5);
        e[159:138] = '0;
        check({tag, "_vec"}, 160'(in_flat), e);
        check({tag, "_cnt"}, 160'(vec_count), 160'(j + 1));
        if (!stl) check({tag, "_gap"}, 160'(gap), 160'(5));
        j++;
        gap = 0;
        stl = 0;
      end else if (in_flat !== prev) stab++;
      prev = in_flat;
    end
    stall = 1'b0;
    check({tag, "_commits"}, 160'(j), 160'(int'(c) + 1));
    check({tag, "_done"}, 160'({busy, done}), 160'(2'b01));
    check({tag, "_final_cnt"}, 160'(vec_count), 160'(c + 32'd1));
    check({tag, "_rng"}, 160'(rng_state), 160'(lcgn(s, (int'(c) + 1) * 5)));
    check({tag, "_stable"}, 160'(stab), 160'(0));
    prev = in_flat;
    repeat (3) begin
      tick;
      if (vec_valid) extra++;
    end
    check({tag, "_extra"}, 160'(extra), 160'(0));
    check({tag, "_hold"}, 160'(in_flat), 160'(prev));
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] c, input bit rnd, input string tag);
    pulse_start(s, c);
    collect(s, c, rnd, 0, tag);
  endtask

  initial begin
    int n;
    logic [31:0] r, t;
    logic [159:0] e;
    tick;
    tick;
    check("rst_flat", 160'(in_flat), 160'(0));
    check("rst_ctl", 160'({vec_valid, busy, done}), 160'(0));
    check("rst_cnt", 160'(vec_count), 160'(0));
    check("rst_rng", 160'(rng_state), 160'(0));
    rst_n = 1'b1;
    repeat (3) tick;
    check("idle_after_rst", 160'({vec_valid, busy, done}), 160'(0));

    run(32'd0, 32'd0, 1'b0, "r032");
    check("r032_w0", 160'(in_flat[31:0]), 160'(32'h00003039));
    check("r032_w1", 160'(in_flat[63:32]), 160'(32'hD3DC167E));

    run(32'd2046968324, 32'd3, 1'b0, "r033");
    t = lcgn(32'd2046968324, 20);
    check("r033_top", 160'(in_flat[137:128]), 160'(t[9:0]));

    r = 32'hCAFE1234;
    pulse_start(r, 32'd0);
    tick;
    tick;
    stall = 1'b1;
    t = rng_state;
    n = 0;
    repeat (7) begin
      tick;
      if (vec_valid) n++;
    end
    check("r034_hold_rng", 160'(rng_state), 160'(t));
    check("r034_no_commit", 160'(n), 160'(0));
    check("r034_busy", 160'(busy), 160'(1));
    stall = 1'b0;
    n = 9;
    while (!vec_valid && n < 60) begin
      tick;
      n++;
    end
    check("r034_latency", 160'(n), 160'(12));
    e = vec(r, 0, 5);
    e[159:138] = '0;
    check("r034_vec", 160'(in_flat), e);

    r = 32'h13579BDF;
    pulse_start(r, 32'd1);
    tick;
    tick;
    seed = 32'hDEADBEEF;
    cycles = 32'd7;
    start = 1'b1;
    tick;
    start = 1'b0;
    collect(r, 32'd1, 1'b0, 3, "r035a");
    pulse_start(32'h2468ACE0, 32'd0);
    check("r035_restart_cnt", 160'(vec_count), 160'(0));
    check("r035_restart_rng", 160'(rng_state), 160'(32'h2468ACE0));
    check("r035_restart_busy", 160'({busy, done}), 160'(2'b10));
    collect(32'h2468ACE0, 32'd0, 1'b0, 0, "r035b");

    pulse_start(32'h0BADF00D, 32'd5);
    n = 0;
    while (!vec_valid && n < 60) begin
      tick;
      n++;
    end
    check("r036_first", 160'(vec_valid), 160'(1));
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("r036_flat", 160'(in_flat), 160'(0));
    check("r036_ctl", 160'({vec_valid, busy, done}), 160'(0));
    check("r036_cnt_rng", 160'({vec_count, rng_state}), 160'(0));
    n = 0;
    repeat (4) begin
      tick;
      if (vec_valid) n++;
    end
    check("r036_no_valid", 160'(n), 160'(0));
    rst_n = 1'b1;
    repeat (3) tick;
    check("r036_idle", 160'({vec_valid, busy, done}), 160'(0));

    r = $urandom;
    seed2 = r;
    cycles2 = 32'd2;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    check("r037_fill", 160'({vec_valid2, busy2}), 160'(2'b01));
    for (int j = 0; j < 3; j++) begin
      tick;
      check("r037_valid", 160'(vec_valid2), 160'(1));
      check("r037_vec", 160'(in_flat2), 160'(lcgn(r, j + 1)));
    end
    check("r037_done", 160'({busy2, done2}), 160'(2'b01));
    check("r037_cnt", 160'(vec_count2), 160'(3));
    tick;
    check("r037_end", 160'(vec_valid2), 160'(0));

    for (int i = 0; i < 5; i++) run($urandom, $urandom_range(0, 3), 1'b1, "rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
